fpu_req_arbiter: RTL
====================

Name: fpu_req_arbiter

Overview:
- Sequences a shared, non-pipelined floating-point add/sub unit with fixed result latency between two requesters (ports 0 and 1).
- Arbitrates round-robin, registers the winner's operands and opcode, and pulses the unit's start.
- Waits the fixed latency, then captures the unit's result and returns it tagged with the requester id.
- Sits between requester front-ends and the FPU datapath; only one operation is in flight at a time.

Parameters:
WIDTH, 32, operand/result width
OPW, 3, opcode width; passed through unmodified (bit 0 = 0 add, 1 sub)
LAT, 4, FPU cycles from the start cycle to a valid fpu_out; legal range 1..15

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
req0  input  1  requester 0 request
opa0  input  WIDTH  requester 0 operand A
opb0  input  WIDTH  requester 0 operand B
op0  input  OPW  requester 0 opcode
gnt0  output  1  requester 0 grant, one-cycle pulse
req1, opa1, opb1, op1, gnt1: same as port 0, for requester 1
fpu_start  output  1  start pulse to the FPU
fpu_opa  output  WIDTH  registered operand A to the FPU
fpu_opb  output  WIDTH  registered operand B to the FPU
fpu_op  output  OPW  registered opcode to the FPU
fpu_out  input  WIDTH  FPU result, valid LAT cycles after the start cycle
res_valid  output  1  result valid, one-cycle pulse
res_data  output  WIDTH  captured result
res_id  output  1  requester that owns res_data
busy  output  1  high whenever state != IDLE

Behaviour:
- Asynchronous rst:
  - state=IDLE; all outputs 0.
  - rr_last=1, so port 0 wins the first tie.
  - Latency counter cleared.
- Reset mid-operation aborts the job; the late FPU result is never captured; no res_valid is produced.
- All outputs are registered. States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - At the edge E0 where req0|req1 is sampled, choose the winner:
    - Only one requesting: that port wins.
    - Both requesting: the port != rr_last wins.
  - At E0, latch the winner's opa/opb/op into fpu_opa/fpu_opb/fpu_op, set owner=winner, set rr_last=winner, go to ISSUE.
- ISSUE (cycle E0→E1):
  - gnt_owner=1 and fpu_start=1 for exactly this cycle.
  - At E1: load the counter with LAT, go to WAIT.
- WAIT (LAT cycles, E1→E(LAT+1)):
  - Counter decrements each edge.
  - At the edge where the counter equals 1: capture fpu_out into res_data, set res_id=owner, go to DONE.
- DONE (one cycle):
  - res_valid=1.
  - At the next edge: res_valid=0, go to IDLE.
  - res_data and res_id hold their values until the next capture.
- Latency: res_valid rises at edge E0+LAT+1 and is high for 1 cycle. Throughput is one operation per LAT+3 cycles.
- fpu_opa/fpu_opb/fpu_op hold stable from E0 until the next IDLE sample, so the FPU sees constant inputs throughout.
- Requests are sampled only in IDLE. Requests held during ISSUE/WAIT/DONE are not lost; they are arbitrated at the first IDLE edge.
- A requester holds req and operands until it sees gnt, then deasserts req the following cycle. A req still high in IDLE is treated as a new request.
- Operands are sampled at E0, not at gnt. A requester changing operands between E0 and gnt has no effect on the in-flight job.
- gnt0 and gnt1 are never high together. fpu_start is never high outside ISSUE.
- Counter width: 4 bits.

Test Plan:
- LAT=4, req0=1 with opa0=32'h3F800000, opb0=32'h40000000, op0=0, and fpu_out model returning opa+opb-style token 32'h40400000:
  - gnt0 and fpu_start high in the cycle after E0.
  - res_valid pulses at E0+5 with res_data=32'h40400000, res_id=0.
  - busy high E0..E0+6.
- req0=req1=1 from reset, held continuously, ops distinct:
  - Grants alternate 0,1,0,1.
  - Successive res_valid pulses are spaced 7 cycles apart (LAT=4).
  - res_id alternates 0,1,0,1.
- req1 asserted during WAIT of a port-0 job:
  - No gnt1 until the state returns to IDLE.
  - gnt1 pulses exactly 1 cycle after the IDLE sample.
  - The port-0 result is unaffected.
- rst asserted asynchronously mid-WAIT (counter=2):
  - All outputs 0 immediately.
  - No res_valid for the aborted job.
  - The next single req1 is granted normally, with rr_last reset so a simultaneous req0/req1 grants 0 first.
- LAT=1 build, single req0:
  - fpu_out sampled at E0+2.
  - res_valid at E0+2.
  - Operation completes in 4 cycles.
- Operands of port 0 changed in the ISSUE cycle:
  - fpu_opa/fpu_opb retain the E0-sampled values through DONE.
  - res_data reflects the original operands.

Source files
------------

// File: rtl/fpu_req_arbiter.sv
// Round-robin sequencer sharing one non-pipelined FP add/sub unit between two requesters.
// One job in flight: grant/start pulse, wait the fixed unit latency, return the tagged result.
module fpu_req_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3,
  parameter int unsigned LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] opa0,
  input  logic [WIDTH-1:0] opb0,
  input  logic [OPW-1:0]   op0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] opa1,
  input  logic [WIDTH-1:0] opb1,
  input  logic [OPW-1:0]   op1,
  output logic             gnt1,
  output logic             fpu_start,
  output logic [WIDTH-1:0] fpu_opa,
  output logic [WIDTH-1:0] fpu_opb,
  output logic [OPW-1:0]   fpu_op,
  input  logic [WIDTH-1:0] fpu_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             rr_last_q,   rr_last_d;
  logic             owner_q,     owner_d;
  logic             gnt0_q,      gnt0_d;
  logic             gnt1_q,      gnt1_d;
  logic             start_q,     start_d;
  logic [WIDTH-1:0] opa_q,       opa_d;
  logic [WIDTH-1:0] opb_q,       opb_d;
  logic [OPW-1:0]   op_q,        op_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic             res_id_q,    res_id_d;
  logic             busy_q,      busy_d;

  logic any_req;
  logic winner;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    any_req = req0 | req1;
    winner  = (req0 & req1) ? ~rr_last_q : req1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    start_d     = 1'b0;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d   = winner;
          rr_last_d = winner;
          opa_d     = winner ? opa1 : opa0;
          opb_d     = winner ? opb1 : opb0;
          op_d      = winner ? op1  : op0;
          gnt0_d    = ~winner;
          gnt1_d    = winner;
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Result is valid on the edge where the countdown reaches its last cycle.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d       = '0;
          res_data_d  = fpu_out;
          res_id_d    = owner_q;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      start_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      start_q     <= start_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign fpu_start = start_q;
  assign fpu_opa   = opa_q;
  assign fpu_opb   = opb_q;
  assign fpu_op    = op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule
